screen_painter: RTL and testbench

SCREEN_PAINTER -- requirements
Module: screen_painter

---
 rtl/screen_pkg.sv | 26 ++
 rtl/screen_painter_if.sv | 36 +++
 rtl/raster_counter.sv | 46 ++++
 rtl/screen_painter.sv | 147 ++++++++++++++
 tb/tb_screen_painter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/screen_pkg.sv
// Shared types and default constants for the screen painter block.
package screen_pkg;

  localparam int DEF_H_RES    = 160;
  localparam int DEF_V_RES    = 120;
  localparam int DEF_COLOUR_W = 3;

  typedef enum logic [1:0] {
    MODE_BLACK    = 2'd0,
    MODE_TITLE    = 2'd1,
    MODE_GAMEOVER = 2'd2,
    MODE_FLASH    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int addr_width(input int h_res, input int v_res);
    return $clog2(h_res * v_res);
  endfunction

endpackage

// File: rtl/screen_painter_if.sv
// Frame request, image ROM and pixel plot signals of the screen painter.
interface screen_painter_if
  import screen_pkg::*;
#(
  parameter int H_RES    = DEF_H_RES,
  parameter int V_RES    = DEF_V_RES,
  parameter int COLOUR_W = DEF_COLOUR_W
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int AW = addr_width(H_RES, V_RES);

  logic                start;
  logic [1:0]          mode;
  logic [AW-1:0]       rom_addr;
  logic [COLOUR_W-1:0] rom_data;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                busy;
  logic                done;

  // Host side: requests frames and supplies ROM data.
  modport master (
    output start, mode, rom_data,
    input  rom_addr, x, y, colour, plot, busy, done
  );

  // Painter side.
  modport slave (
    input  start, mode, rom_data,
    output rom_addr, x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/raster_counter.sv
// Raster-order x/y/address counters with column wrap and last-pixel flag.
module raster_counter #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                en,
  output logic [$clog2(H_RES)-1:0]            x,
  output logic [$clog2(V_RES)-1:0]            y,
  output logic [$clog2(H_RES*V_RES)-1:0]      addr,
  output logic                                last
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [XW-1:0] X_MAX = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_RES - 1);

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [$clog2(H_RES*V_RES)-1:0] addr_reg;

  assign x    = x_reg;
  assign y    = y_reg;
  assign addr = addr_reg;
  assign last = (x_reg == X_MAX) && (y_reg == Y_MAX);

  // The address is a plain running count, so no multiply of y by H_RES is needed.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x_reg    <= '0;
      y_reg    <= '0;
      addr_reg <= '0;
    end else if (en) begin
      addr_reg <= last ? '0 : addr_reg + 1'b1;
      if (x_reg == X_MAX) begin
        x_reg <= '0;
        y_reg <= (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/screen_painter.sv
// Paints one full frame per request from an external image ROM or a solid colour.
// Optional flashing mode 3 is built when SCREEN_PAINTER_FLASH_EN is defined.
module screen_painter
  import screen_pkg::*;
#(
  parameter int                  H_RES       = DEF_H_RES,
  parameter int                  V_RES       = DEF_V_RES,
  parameter int                  COLOUR_W    = DEF_COLOUR_W,
  parameter logic [COLOUR_W-1:0] FILL_COLOUR = 3'b100,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR  = 3'b100
) (
  input  logic            clk,
  input  logic            rst,
  screen_painter_if.slave bus
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam int AW = addr_width(H_RES, V_RES);

  state_e              state_reg;
  mode_e               mode_reg;
  logic                issued_all_reg;
  logic                plot_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [XW-1:0]       x_reg;
  logic [YW-1:0]       y_reg;
  logic [COLOUR_W-1:0] colour_hold_reg;
  logic [COLOUR_W-1:0] pixel_colour;

  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_last;
  logic [XW-1:0]       cnt_x;
  logic [YW-1:0]       cnt_y;
  logic [AW-1:0]       cnt_addr;
  logic                flash_phase;
  logic                flash_sub;

  assign cnt_clr = (state_reg == ST_IDLE) && bus.start;
  assign cnt_en  = (state_reg == ST_DRAW) && !issued_all_reg;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .x    (cnt_x),
    .y    (cnt_y),
    .addr (cnt_addr),
    .last (cnt_last)
  );

`ifdef SCREEN_PAINTER_FLASH_EN
  logic phase_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= 1'b0;
    end else if (state_reg == ST_FLUSH && mode_reg == MODE_FLASH) begin
      phase_reg <= ~phase_reg;
    end
  end

  assign flash_phase = phase_reg;
`else
  assign flash_phase = 1'b0;
`endif

  assign flash_sub = flash_phase && (bus.rom_data == KEY_COLOUR);

  always_comb begin
    pixel_colour = bus.rom_data;
    case (mode_reg)
      MODE_BLACK:    pixel_colour = BG_COLOUR;
      MODE_TITLE:    pixel_colour = bus.rom_data;
      MODE_GAMEOVER: pixel_colour = FILL_COLOUR;
      MODE_FLASH:    pixel_colour = flash_sub ? BG_COLOUR : bus.rom_data;
      default:       pixel_colour = bus.rom_data;
    endcase
  end

  // DRAW keeps one extra cycle after the last address so the final pixel
  // drains through the ROM stage before FLUSH and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      mode_reg        <= MODE_BLACK;
      issued_all_reg  <= 1'b0;
      plot_reg        <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      colour_hold_reg <= '0;
    end else begin
      plot_reg <= cnt_en;
      done_reg <= 1'b0;
      if (cnt_en) begin
        x_reg <= cnt_x;
        y_reg <= cnt_y;
      end
      if (plot_reg) begin
        colour_hold_reg <= pixel_colour;
      end
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            mode_reg       <= mode_e'(bus.mode);
            issued_all_reg <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (issued_all_reg) begin
            state_reg <= ST_FLUSH;
          end else if (cnt_last) begin
            issued_all_reg <= 1'b1;
          end
        end
        ST_FLUSH: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr = cnt_addr;
  assign bus.x        = x_reg;
  assign bus.y        = y_reg;
  assign bus.plot     = plot_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.colour   = plot_reg ? pixel_colour : colour_hold_reg;

endmodule

// File: tb/tb_screen_painter.sv
// Self-checking bench for screen_painter on a 4x2 screen with a ROM returning addr[2:0].
module tb_screen_painter;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;
  localparam int MAXC = 512;
`ifdef SCREEN_PAINTER_FLASH_EN
  localparam bit FLASH_EN = 1'b1;
`else
  localparam bit FLASH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  screen_painter_if #(.H_RES(H), .V_RES(V), .COLOUR_W(3)) bus ();

  screen_painter #(.H_RES(H), .V_RES(V), .COLOUR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One-cycle-latency image ROM.
  always @(posedge clk) bus.rom_data <= bus.rom_addr[2:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour indexed by absolute cycle number.
  bit         e_plot [MAXC];
  bit         e_busy [MAXC];
  bit         e_done [MAXC];
  bit         e_rst  [MAXC];
  logic [1:0] e_x    [MAXC];
  logic       e_y    [MAXC];
  logic [2:0] e_c    [MAXC];
  int         next_idle = 0;
  bit         phase = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] hx = '0;
  logic       hy = '0;
  logic [2:0] hc = '0;
  logic [2:0] dut_pix [NPIX];
  int plot_cnt, first_plot, last_plot, last_done, step_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input logic [1:0] m, input int k, input bit ph);
    logic [2:0] d;
    d = 3'(k);
    case (m)
      2'd0:    return 3'b000;
      2'd1:    return d;
      2'd2:    return 3'b100;
      default: return (FLASH_EN && ph && d == 3'b100) ? 3'b000 : d;
    endcase
  endfunction

  // Frame accepted in cycle c: busy c+1..c+10, plots c+2..c+9, done c+11, idle at c+12.
  task automatic model_apply(input int c, input logic s, input logic [1:0] m, input logic r);
    if (r) begin
      for (int n = c + 1; n < MAXC; n++) begin
        e_plot[n] = 1'b0;
        e_busy[n] = 1'b0;
        e_done[n] = 1'b0;
      end
      e_rst[c+1] = 1'b1;
      next_idle  = c + 1;
      phase      = 1'b0;
    end else if (s && c >= next_idle && c + 12 < MAXC) begin
      for (int k = 0; k < NPIX; k++) begin
        e_plot[c+2+k] = 1'b1;
        e_x[c+2+k]    = 2'(k % H);
        e_y[c+2+k]    = 1'(k / H);
        e_c[c+2+k]    = exp_colour(m, k, phase);
      end
      for (int n = c + 1; n <= c + 10; n++) e_busy[n] = 1'b1;
      e_done[c+11] = 1'b1;
      next_idle    = c + 12;
      if (m == 2'd3 && FLASH_EN) phase = ~phase;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (e_rst[cyc]) begin
        hx = '0;
        hy = '0;
        hc = '0;
      end
      if (e_plot[cyc]) begin
        hx = e_x[cyc];
        hy = e_y[cyc];
        hc = e_c[cyc];
      end
      check("plot", 32'(bus.plot), 32'(e_plot[cyc]));
      check("busy", 32'(bus.busy), 32'(e_busy[cyc]));
      check("done", 32'(bus.done), 32'(e_done[cyc]));
      check("x", 32'(bus.x), 32'(hx));
      check("y", 32'(bus.y), 32'(hy));
      check("colour", 32'(bus.colour), 32'(hc));
      if (bus.plot === 1'b1) begin
        dut_pix[{bus.y, bus.x}] = bus.colour;
        plot_cnt++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
      end
      if (bus.done === 1'b1) last_done = cyc;
    end
  end

  task automatic step(input logic s, input logic [1:0] m, input logic r);
    @(posedge clk);
    #1;
    bus.start = s;
    bus.mode  = m;
    rst       = r;
    step_cyc  = cyc;
    model_apply(cyc, s, m, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0);
  endtask

  task automatic clear_log();
    plot_cnt   = 0;
    first_plot = -1;
    last_plot  = -1;
    last_done  = -1;
    for (int i = 0; i < NPIX; i++) dut_pix[i] = 3'bxxx;
  endtask

  task automatic frame(input logic [1:0] m, output int s);
    clear_log();
    step(1'b1, m, 1'b0);
    s = step_cyc;
    idle(13);
  endtask

  int s;

  initial begin
    bus.start = 1'b0;
    bus.mode  = 2'd0;
    clear_log();
    model_apply(0, 1'b0, 2'd0, 1'b1);
    step(1'b0, 2'd0, 1'b1);
    idle(2);

    // TITLE frame: ROM image passes straight through.
    frame(2'd1, s);
    check("title_first_plot", 32'(first_plot), 32'(s + 2));
    check("title_last_plot", 32'(last_plot), 32'(s + 9));
    check("title_done", 32'(last_done), 32'(s + 11));
    check("title_count", 32'(plot_cnt), 32'd8);
    check("title_pix0", 32'(dut_pix[0]), 32'd0);
    check("title_pix7", 32'(dut_pix[7]), 32'd7);

    // GAMEOVER and BLACK solid fills.
    frame(2'd2, s);
    check("gameover_count", 32'(plot_cnt), 32'd8);
    for (int i = 0; i < NPIX; i++) check("gameover_pix", 32'(dut_pix[i]), 32'd4);
    frame(2'd0, s);
    check("black_count", 32'(plot_cnt), 32'd8);
    for (int i = 0; i < NPIX; i++) check("black_pix", 32'(dut_pix[i]), 32'd0);

    // FLASH twice: the key colour is replaced only in the second frame.
    frame(2'd3, s);
    check("flash1_pix4", 32'(dut_pix[4]), 32'd4);
    check("flash1_pix5", 32'(dut_pix[5]), 32'd5);
    frame(2'd3, s);
    check("flash2_pix4", 32'(dut_pix[4]), FLASH_EN ? 32'd0 : 32'd4);
    check("flash2_pix5", 32'(dut_pix[5]), 32'd5);
    check("flash2_pix3", 32'(dut_pix[3]), 32'd3);

    // Reset in cycle 5 of a frame aborts it without done.
    clear_log();
    step(1'b1, 2'd1, 1'b0);
    s = step_cyc;
    idle(4);
    step(1'b0, 2'd0, 1'b1);
    idle(3);
    check("abort_count", 32'(plot_cnt), 32'd4);
    check("abort_no_done", 32'(last_done), 32'hFFFF_FFFF);
    frame(2'd1, s);
    check("after_abort_count", 32'(plot_cnt), 32'd8);
    check("after_abort_pix6", 32'(dut_pix[6]), 32'd6);

    // Requests during DRAW and in the DONE cycle are ignored.
    clear_log();
    step(1'b1, 2'd2, 1'b0);
    s = step_cyc;
    idle(2);
    step(1'b1, 2'd1, 1'b0);
    idle(7);
    step(1'b1, 2'd3, 1'b0);
    idle(4);
    check("ignore_count", 32'(plot_cnt), 32'd8);
    check("ignore_done", 32'(last_done), 32'(s + 11));
    for (int i = 0; i < NPIX; i++) check("ignore_pix", 32'(dut_pix[i]), 32'd4);

    // start held high restarts on the first IDLE cycle.
    clear_log();
    step(1'b1, 2'd1, 1'b0);
    s = step_cyc;
    for (int i = 0; i < 12; i++) step(1'b1, 2'd1, 1'b0);
    idle(14);
    check("held_count", 32'(plot_cnt), 32'd16);
    check("held_done", 32'(last_done), 32'(s + 23));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
